// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor (a - b), one full-subtractor cell,
// LSB first, with a start/busy/done handshake and registered results.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic fs_diff(input logic ai, input logic bi, input logic br);
    return ai ^ bi ^ br;
  endfunction

  function automatic logic fs_borrow(input logic ai, input logic bi, input logic br);
    return (~ai & bi) | (~(ai ^ bi) & br);
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, res_r, diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r, borrow_r, busy_r, done_r;
  logic             load_s, step_s, last_s, d_s, bnext_s;
  logic [WIDTH-1:0] res_next_s;

  assign d_s        = fs_diff(a_sh_r[0], b_sh_r[0], br_r);
  assign bnext_s    = fs_borrow(a_sh_r[0], b_sh_r[0], br_r);
  assign res_next_s = {d_s, res_r[WIDTH-1:1]};

  // Next-state and datapath control decode
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    last_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          load_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_C) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand shifters, borrow, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      br_r     <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      // flags track the state being entered so they stay registered
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
      if (load_s) begin
        a_sh_r <= a;
        b_sh_r <= b;
        br_r   <= 1'b0;
        cnt_r  <= {CW{1'b0}};
      end else if (step_s) begin
        a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
        res_r  <= res_next_s;
        br_r   <= bnext_s;
        cnt_r  <= cnt_r + ONE_C;
      end
      if (last_s) begin
        diff_r   <= res_next_s;
        borrow_r <= bnext_s;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 scenarios plus
// an exhaustive WIDTH=4 sweep on a second instance).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;
  logic       start4 = 1'b0;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_diff = 8'h00;
  logic       prev_bo = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation; poke=1 pulses start with other operands mid-run.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input bit poke);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("run_busy", {31'd0, busy8}, 32'd1);
      check("run_nodone", {31'd0, done8}, 32'd0);
      check("run_hold", {23'd0, bo8, diff8}, {23'd0, prev_bo, prev_diff});
      if (poke && i == 2) begin
        a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      tick();
    end
    check("done_pulse", {30'd0, busy8, done8}, 32'd1);
    check("result", {23'd0, bo8, diff8}, {23'd0, eb, ed});
    prev_diff = ed; prev_bo = eb;
    tick();
    check("idle_after", {30'd0, busy8, done8}, 32'd0);
    check("idle_hold", {23'd0, bo8, diff8}, {23'd0, prev_bo, prev_diff});
  endtask

  initial begin
    logic [4:0] exp5;
    rst = 1'b1;
    tick();
    tick();
    check("rst_state8", {22'd0, busy8, done8, bo8, diff8}, 32'd0);
    check("rst_state4", {25'd0, busy4, done4, bo4, diff4}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_flags", {30'd0, busy8, done8}, 32'd0);

    op8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    op8(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    op8(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);
    op8(8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0);

    // reset in the 4th RUN cycle discards the operation
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_run", {22'd0, busy8, done8, bo8, diff8}, 32'd0);
    prev_diff = 8'h00; prev_bo = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_done_after_rst", {30'd0, busy8, done8}, 32'd0);
    end
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);

    // back-to-back with start held high
    a8 = 8'h0A; b8 = 8'h0B; start8 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("b2b_busy1", {30'd0, busy8, done8}, 32'd2);
      tick();
    end
    check("b2b_done1", {30'd0, busy8, done8}, 32'd1);
    check("b2b_res1", {23'd0, bo8, diff8}, {23'd0, 1'b1, 8'hFF});
    a8 = 8'h20; b8 = 8'h10;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("b2b_busy2", {30'd0, busy8, done8}, 32'd2);
      check("b2b_hold", {23'd0, bo8, diff8}, {23'd0, 1'b1, 8'hFF});
      tick();
    end
    check("b2b_done2", {30'd0, busy8, done8}, 32'd1);
    check("b2b_res2", {23'd0, bo8, diff8}, {23'd0, 1'b0, 8'h10});
    tick();

    // exhaustive WIDTH=4, back-to-back through DONE
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        tick();
        tick();
        exp5 = {1'b0, 4'(x)} - {1'b0, 4'(y)};
        check("w4_result", {25'd0, busy4, done4, bo4, diff4}, {25'd0, 2'b01, exp5});
      end
    end
    tick();
    check("w4_idle", {30'd0, busy4, done4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor (A - B) built around a single full-subtractor bit cell and a registered borrow. It sits upstream of the full-subtractor cell and sequences operands into it, one bit per clock, LSB first. It collects the difference bits and the final borrow into registered outputs. A start/busy/done handshake connects it to a controlling stage.

Parameters:
WIDTH, 8, operand and result width in bits; legal range is 2 or more.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a subtraction; sampled only in IDLE or DONE
a  input  WIDTH  minuend; sampled on the edge that accepts start
b  input  WIDTH  subtrahend; sampled on the edge that accepts start
busy  output  1  high while bits are being processed (RUN state)
done  output  1  single-cycle pulse: diff and borrow_out have just been updated
diff  output  WIDTH  registered result, (a - b) mod 2^WIDTH
borrow_out  output  1  registered final borrow; 1 when a < b (unsigned)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). Every register updates only on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0. Internal shift registers, borrow register and bit counter are also cleared.
- rst has priority over every other input, including start on the same edge.
- Bit-cell equations:
  - d = ai ^ bi ^ br
  - bnext = (~ai & bi) | (~(ai ^ bi) & br)
  - ai and bi are the current LSBs of the operand shift registers; br is the borrow register.
- State machine states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: load a and b into the shift registers, set br=0, set count=0, go to RUN.
- RUN:
  - busy=1.
  - Each edge: shift d into the MSB of the result shift register (right shift). Shift both operand registers right by 1. Set br=bnext and count=count+1.
  - On the edge that processes bit WIDTH-1 (count==WIDTH-1):
    - Copy the completed result into diff and bnext into borrow_out.
    - Go to DONE.
  - start is ignored while in RUN. No restart and no operand reload.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1 in DONE: accept new operands exactly as in IDLE and go to RUN, giving back-to-back operation. Otherwise go to IDLE.
- Latency: if start is accepted at edge E, busy=1 after edges E through E+WIDTH-1. done=1, diff and borrow_out become valid after edge E+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- diff and borrow_out change only on the completing edge or on reset. They hold their value through IDLE and through the following RUN.
- Reset mid-RUN: the operation is discarded. All outputs return to their reset values on that edge, and no done pulse is produced.
- a and b may change freely after the accepting edge; they have no effect until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH. Invariant: {borrow_out, diff} equals the WIDTH+1-bit result of a - b with the borrow as sign.
- busy and done are never high in the same cycle.

Test Plan:
- WIDTH=8; a=0x05, b=0x03, start for one cycle -> busy high for 8 cycles, then done pulse; diff=0x02, borrow_out=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Also a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Also a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0.
- a=0x00, b=0x00, then a=0xFF, b=0xFF -> diff=0x00, borrow_out=0 in both cases; previous outputs hold until the done pulse.
- While busy (a=0x10, b=0x01 in progress), pulse start with a=0x00, b=0xFF -> ignored; result is diff=0x0F, borrow_out=0 after exactly 8 busy cycles.
- Assert rst at the 4th RUN cycle -> next cycle busy=0, done=0, diff=0x00, borrow_out=0, and no done pulse. Then start a=0x80, b=0x01 -> diff=0x7F.
- Back-to-back: hold start high with a=0x0A, b=0x0B, then with a=0x20, b=0x10 during the done cycle -> first done gives 0xFF/1. busy reasserts the next cycle, and the second done comes 9 cycles after the first with 0x10/0.
- Exhaustive check at WIDTH=4: all 256 (a,b) pairs compared against the reference {borrow, diff} = a - b.
